dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Shares the single data-memory port (`dmem`) between two requesters: the pipeline MEM stage (port 0, primary) and an auxiliary requester such as a program loader or debug unit (port 1, secondary). One access per cycle with fixed priority to port 0. A starvation counter forces a port-1 grant after a bounded number of consecutive port-0 wins. The block produces the pipeline stall (wired to the stage `reg_lock` inputs) and a registered request/acknowledge handshake for port 1.

## Interface
- `STARVE_LIMIT`, 4: maximum consecutive port-0 grants while port 1 waits; range 1–15.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `p0_req` in 1: MEM-stage access request (load or store) this cycle.
- `p0_we` in 1: port-0 write enable.
- `p0_addr` in [0:31]: port-0 byte address.
- `p0_wdata` in [0:31]: port-0 store data.
- `p0_dsize` in [0:1]: port-0 size (3 = word, 1 = halfword, 0 = byte).
- `p0_rdata` out [0:31]: `mem_rdata` passthrough.
- `p0_stall` out 1: port 0 not served this cycle; drives pipeline `reg_lock`.
- `p1_req` in 1: port-1 request; held high with stable fields until `p1_ack`.
- `p1_we` in 1: port-1 write enable.
- `p1_addr` in [0:31]: port-1 byte address.
- `p1_wdata` in [0:31]: port-1 write data.
- `p1_dsize` in [0:1]: port-1 size.
- `p1_rdata` out [0:31]: registered read data, valid while `p1_ack` = 1.
- `p1_ack` out 1: one-cycle completion pulse.
- `mem_addr` out [0:31]: to `dmem` `addr`.
- `mem_wdata` out [0:31]: to `dmem` `wData`.
- `mem_we` out 1: to `dmem` `writeEnable`.
- `mem_dsize` out [0:1]: to `dmem` `dsize`.
- `mem_rdata` in [0:31]: from `dmem` `rData`, combinational.

## Operation
- **Port-1 FSM states.**
  - P1_IDLE: `p1_ack` = 0.
  - P1_ACK: `p1_ack` = 1. Lasts exactly one cycle, then returns to P1_IDLE.
- **`p1_eligible`** = `p1_req` && state == P1_IDLE.
- **Grant (combinational):** `gnt1` = `p1_eligible` && (!`p0_req` || `starve_cnt` == `STARVE_LIMIT`). `gnt0` = `p0_req` && !`gnt1`.
- **Memory mux:**
  - `gnt1`: `mem_*` take the `p1_*` fields.
  - `gnt0`: `mem_*` take the `p0_*` fields.
  - Neither: `mem_addr` = 0, `mem_wdata` = 0, `mem_dsize` = 0, `mem_we` = 0.
  - `mem_we` is forced to 0 while `reset` = 1.
- **`p0_stall`** = `p0_req` && `gnt1`.
- **`p0_rdata`** = `mem_rdata` every cycle. It is meaningful only when `gnt0` and !`p0_we`.
- **On a `gnt1` edge:**
  - `p1_rdata` <= `mem_rdata`. On writes it captures the pre-write contents.
  - State goes to P1_ACK.
  - `starve_cnt` <= 0.
- **`starve_cnt` (4 bits):**
  - Increments, saturating at `STARVE_LIMIT`, on edges where `gnt0` && `p1_eligible`.
  - Clears to 0 when !`p1_eligible` or `gnt1`.
- `p1_rdata` holds its value until the next port-1 grant.
- **Reset values:** state P1_IDLE, `starve_cnt` 0, `p1_ack` 0, `p1_rdata` 0. Combinational outputs follow the rules above with state = idle.
- Illegal `dsize` = 2 is passed through unmodified; `dmem` reports it.

## Timing
- **Port 0:** zero added latency when granted. Load data is valid in the same cycle, writes commit at that cycle's edge. A stalled cycle repeats on the next edge; the request must be held.
- **Port 1:** grant in cycle N (earliest the cycle `p1_req` rises), `p1_ack` in N+1, next eligibility in N+2.
  - Back-to-back port-1 accesses therefore take one per two cycles.
  - The requester may drop `p1_req` or present a new request in N+1; it is ignored until N+2.
- **Worst-case port-1 wait** under continuous `p0_req`: `STARVE_LIMIT` cycles, then grant in the following cycle.
- **Simultaneous requests with counter below limit:** port 0 wins.
- **Counter at limit:** port 1 wins and `p0_stall` = 1 for exactly that cycle.
- **`p1_req` dropped before grant** (protocol violation): the counter clears and nothing is issued.
- **Reset asserted mid-access:**
  - The in-flight port-1 access is discarded and no ack is issued.
  - `mem_we` goes to 0 immediately (asynchronous), so no write commits at a clock edge during reset.

## Test plan
- **Reset check:** assert `reset` mid-cycle with `p0_req` = 1, `p0_we` = 1 -> `mem_we` = 0 immediately; `p1_ack` = 0, `p1_rdata` = 0; no memory change at the following edge.
- **Port-0 only:** store word 0xDEADBEEF at 0x100, then load 0x100 -> `p0_stall` = 0 both cycles; `p0_rdata` = 0xDEADBEEF in the load cycle.
- **Port-1 only:** write byte 0xA5 at 0x203 (`dsize` 0), then read 0x200 -> each access acked one cycle after grant; read `p1_rdata` low byte = 0xA5; second grant no earlier than 2 cycles after the first.
- **Starvation:** `STARVE_LIMIT` = 4, `p0_req` held high, `p1_req` raised at cycle 0 -> port 0 granted cycles 0–3; cycle 4 `p0_stall` = 1 and `mem_addr` = `p1_addr`; `p1_ack` = 1 at cycle 5; `p0_stall` = 0 at cycle 5.
- **Simultaneous idle-counter requests:** both ports request at cycle 0 with `p0_req` low at cycle 1 -> port 0 served cycle 0, port 1 served cycle 1, ack cycle 2.
- **Reset during P1_ACK:** reset asserted in the ack cycle -> `p1_ack` drops asynchronously; after release, state is P1_IDLE and `starve_cnt` = 0; a held `p1_req` is granted on the first post-reset cycle with `p0_req` = 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port: pipeline MEM stage (port 0) has zero-latency priority; aux port 1 gets a registered ack.
// Port 0 is held off via p0_stall only when port 1 is granted; a starvation counter bounds port-1 waiting.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [1:0]  p0_dsize,
  output logic [31:0] p0_rdata,
  output logic        p0_stall,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_dsize,
  output logic [31:0] p1_rdata,
  output logic        p1_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [1:0]  mem_dsize,
  input  logic [31:0] mem_rdata
);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dsize;
  } dmem_req_t;

  localparam logic [0:0] P1_IDLE = 1'b0;
  localparam logic [0:0] P1_ACK  = 1'b1;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  logic [0:0] state;
  logic [3:0] starve_cnt;
  logic       p1_eligible;
  logic       gnt0;
  logic       gnt1;
  dmem_req_t  req0;
  dmem_req_t  req1;
  dmem_req_t  sel;

  assign req0 = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, dsize: p0_dsize};
  assign req1 = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, dsize: p1_dsize};

  assign p1_eligible = p1_req && (state == P1_IDLE);
  assign gnt1        = p1_eligible && (!p0_req || (starve_cnt == LIMIT));
  assign gnt0        = p0_req && !gnt1;

  always_comb begin
    sel = '0;
    if (gnt1)      sel = req1;
    else if (gnt0) sel = req0;
  end

  // Reset gates the write strobe combinationally so nothing commits at an edge during reset.
  assign mem_we    = sel.we && !reset;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;
  assign mem_dsize = sel.dsize;

  assign p0_rdata = mem_rdata;
  assign p0_stall = p0_req && gnt1;
  assign p1_ack   = (state == P1_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= P1_IDLE;
      starve_cnt <= '0;
      p1_rdata   <= '0;
    end else begin
      if (gnt1) begin
        state    <= P1_ACK;
        p1_rdata <= mem_rdata;
      end else begin
        state    <= P1_IDLE;
      end
      // Counts only cycles where port 1 is actually waiting behind port 0.
      if (!p1_eligible || gnt1)
        starve_cnt <= '0;
      else if (gnt0 && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule
